// File: rtl/overture_io_pkg.sv
// Shared types and sizing helpers for the OVERTURE host-side I/O port.
package overture_io_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/overture_io_fifo.sv
// Power-of-two FIFO with combinational head read and exact occupancy count.
module overture_io_fifo
  import overture_io_pkg::*;
#(
  parameter int DEPTH                   = 8,
  parameter int WIDTH                   = DATA_W,
  parameter bit PUSH_WHEN_FULL_WITH_POP = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO may still take a push when its head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || (PUSH_WHEN_FULL_WITH_POP && do_pop));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/overture_io_port.sv
// Host-side peer of the OVERTURE CPU I/O pins: input and output byte FIFOs plus sticky misuse flags.
module overture_io_port
  import overture_io_pkg::*;
#(
  parameter int    UUID  = 0,
  parameter string NAME  = "",
  parameter int    DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arch_input_enable,
  output byte_t                   arch_input_value,
  input  logic                    arch_output_enable,
  input  byte_t                   arch_output_value,
  input  logic                    in_valid,
  input  byte_t                   in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output byte_t                   out_data,
  input  logic                    out_ready,
  output logic [cnt_w(DEPTH)-1:0] in_count,
  output logic [cnt_w(DEPTH)-1:0] out_count,
  output logic                    underflow,
  output logic                    overflow,
  input  logic                    clear_flags
);

  byte_t in_head;
  logic  in_full, in_empty, in_push, in_pop;
  logic  out_full, out_empty, out_push, out_pop;
  logic  underflow_q, underflow_d;
  logic  overflow_q, overflow_d;

  // Ready depends only on stored occupancy, never on this cycle's pop.
  assign in_ready         = !in_full;
  assign in_push          = in_valid && !in_full;
  assign in_pop           = arch_input_enable && !in_empty;
  assign arch_input_value = in_empty ? '0 : in_head;

  assign out_valid = !out_empty;
  assign out_pop   = out_valid && out_ready;
  assign out_push  = arch_output_enable && (!out_full || out_pop);

  overture_io_fifo #(
    .DEPTH                   (DEPTH),
    .WIDTH                   (DATA_W),
    .PUSH_WHEN_FULL_WITH_POP (1'b0)
  ) u_in_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_push),
    .data_i  (in_data),
    .pop_i   (in_pop),
    .head_o  (in_head),
    .full_o  (in_full),
    .empty_o (in_empty),
    .count_o (in_count)
  );

  overture_io_fifo #(
    .DEPTH                   (DEPTH),
    .WIDTH                   (DATA_W),
    .PUSH_WHEN_FULL_WITH_POP (1'b1)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (out_push),
    .data_i  (arch_output_value),
    .pop_i   (out_pop),
    .head_o  (out_data),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

  // A fresh event outranks a simultaneous clear.
  always_comb begin
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    if (clear_flags) begin
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
    end
    if (arch_input_enable && in_empty)              underflow_d = 1'b1;
    if (arch_output_enable && out_full && !out_pop) overflow_d  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  assign underflow = underflow_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_overture_io_port.sv
// Directed and scoreboarded checks for overture_io_port with DEPTH=8.
module tb_overture_io_port;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       arch_input_enable;
  logic [7:0] arch_input_value;
  logic       arch_output_enable;
  logic [7:0] arch_output_value;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [3:0] in_count;
  logic [3:0] out_count;
  logic       underflow;
  logic       overflow;
  logic       clear_flags;

  int passed = 0;
  int total  = 0;

  overture_io_port #(.UUID(3), .NAME("tb_port"), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .arch_input_enable  (arch_input_enable),
    .arch_input_value   (arch_input_value),
    .arch_output_enable (arch_output_enable),
    .arch_output_value  (arch_output_value),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .out_ready          (out_ready),
    .in_count           (in_count),
    .out_count          (out_count),
    .underflow          (underflow),
    .overflow           (overflow),
    .clear_flags        (clear_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arch_input_enable  = 1'b0;
    arch_output_enable = 1'b0;
    arch_output_value  = 8'h00;
    in_valid           = 1'b0;
    in_data            = 8'h00;
    out_ready          = 1'b0;
    clear_flags        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (arch_input_value !== 8'h00) $display("FAIL reset_aiv got=%h exp=00", arch_input_value); else passed++;
    total++; if (in_count !== 4'd0 || out_count !== 4'd0) $display("FAIL reset_counts got=%0d/%0d exp=0/0", in_count, out_count); else passed++;
    total++; if (underflow !== 1'b0 || overflow !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", underflow, overflow); else passed++;
    @(negedge clk);
    rst = 1'b0;
    cycle();
    $display("reset: done");
  endtask

  task automatic test_input_basic();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = exp_b[i];
      cycle();
    end
    in_valid = 1'b0;
    total++; if (in_count !== 4'd3) $display("FAIL basic_count got=%0d exp=3", in_count); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (arch_input_value !== exp_b[i]) $display("FAIL basic_read%0d got=%h exp=%h", i, arch_input_value, exp_b[i]); else passed++;
      arch_input_enable = 1'b1;
      cycle();
    end
    arch_input_enable = 1'b0;
    total++; if (in_count !== 4'd0) $display("FAIL basic_count_end got=%0d exp=0", in_count); else passed++;
    total++; if (arch_input_value !== 8'h00) $display("FAIL basic_aiv_empty got=%h exp=00", arch_input_value); else passed++;
    total++; if (underflow !== 1'b0) $display("FAIL basic_no_underflow got=%b exp=0", underflow); else passed++;
    $display("input_basic: 11 22 33 read");
  endtask

  task automatic test_underflow();
    arch_input_enable = 1'b1;
    cycle();
    arch_input_enable = 1'b0;
    total++; if (underflow !== 1'b1) $display("FAIL uf_set got=%b exp=1", underflow); else passed++;
    cycle();
    total++; if (underflow !== 1'b1) $display("FAIL uf_sticky got=%b exp=1", underflow); else passed++;
    clear_flags = 1'b1;
    cycle();
    clear_flags = 1'b0;
    total++; if (underflow !== 1'b0) $display("FAIL uf_clear got=%b exp=0", underflow); else passed++;
    clear_flags = 1'b1;
    arch_input_enable = 1'b1;
    cycle();
    arch_input_enable = 1'b0;
    total++; if (underflow !== 1'b1) $display("FAIL uf_event_beats_clear got=%b exp=1", underflow); else passed++;
    cycle();
    clear_flags = 1'b0;
    total++; if (underflow !== 1'b0) $display("FAIL uf_clear2 got=%b exp=0", underflow); else passed++;
    $display("underflow: set/sticky/clear/priority");
  endtask

  task automatic test_input_full_wrap();
    in_valid = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      in_data = 8'(i);
      cycle();
    end
    total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", in_ready); else passed++;
    total++; if (in_count !== 4'(DEPTH)) $display("FAIL full_count got=%0d exp=%0d", in_count, DEPTH); else passed++;
    in_data = 8'hAA;
    cycle();
    total++; if (in_count !== 4'(DEPTH)) $display("FAIL full_reject got=%0d exp=%0d", in_count, DEPTH); else passed++;
    // CPU pops while full: conservative ready must still refuse the host byte
    arch_input_enable = 1'b1;
    cycle();
    arch_input_enable = 1'b0;
    in_valid = 1'b0;
    total++; if (in_count !== 4'(DEPTH - 1)) $display("FAIL full_pop_no_push got=%0d exp=%0d", in_count, DEPTH - 1); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL full_ready_after_pop got=%b exp=1", in_ready); else passed++;
    in_valid = 1'b1;
    in_data = 8'(DEPTH + 1);
    cycle();
    in_valid = 1'b0;
    for (int i = 2; i <= DEPTH + 1; i++) begin
      total++; if (arch_input_value !== 8'(i)) $display("FAIL wrap_read%0d got=%h exp=%h", i, arch_input_value, 8'(i)); else passed++;
      arch_input_enable = 1'b1;
      cycle();
    end
    arch_input_enable = 1'b0;
    total++; if (in_count !== 4'd0) $display("FAIL wrap_empty got=%0d exp=0", in_count); else passed++;
    $display("input_full_wrap: bytes 1..%0d in order", DEPTH + 1);
  endtask

  task automatic test_output_overflow();
    out_ready = 1'b0;
    arch_output_enable = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      arch_output_value = 8'hC0 + 8'(i);
      cycle();
    end
    total++; if (out_count !== 4'(DEPTH)) $display("FAIL ovf_count got=%0d exp=%0d", out_count, DEPTH); else passed++;
    total++; if (out_valid !== 1'b1 || out_data !== 8'hC0) $display("FAIL ovf_head got=%b/%h exp=1/c0", out_valid, out_data); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_not_yet got=%b exp=0", overflow); else passed++;
    arch_output_value = 8'h5A;
    cycle();
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set got=%b exp=1", overflow); else passed++;
    total++; if (out_count !== 4'(DEPTH)) $display("FAIL ovf_drop_count got=%0d exp=%0d", out_count, DEPTH); else passed++;
    arch_output_value = 8'h5B;
    out_ready = 1'b1;
    cycle();
    arch_output_enable = 1'b0;
    out_ready = 1'b0;
    total++; if (out_count !== 4'(DEPTH)) $display("FAIL ovf_pushpop_count got=%0d exp=%0d", out_count, DEPTH); else passed++;
    total++; if (out_data !== 8'hC1) $display("FAIL ovf_head2 got=%h exp=c1", out_data); else passed++;
    out_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      logic [7:0] e;
      e = (i < DEPTH) ? 8'hC0 + 8'(i) : 8'h5B;
      total++; if (out_data !== e) $display("FAIL ovf_drain%0d got=%h exp=%h", i, out_data, e); else passed++;
      cycle();
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || out_count !== 4'd0) $display("FAIL ovf_drained got=%b/%0d exp=0/0", out_valid, out_count); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else passed++;
    clear_flags = 1'b1;
    cycle();
    clear_flags = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", overflow); else passed++;
    $display("output_overflow: 5A dropped, 5B last out");
  endtask

  task automatic test_async_reset();
    arch_input_enable = 1'b1;
    cycle();
    arch_input_enable = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h40 + 8'(i);
      arch_output_enable = (i < 2);
      arch_output_value = 8'h60 + 8'(i);
      cycle();
    end
    idle_inputs();
    total++; if (in_count !== 4'd3 || out_count !== 4'd2 || underflow !== 1'b1) $display("FAIL ar_prefill got=%0d/%0d/%b exp=3/2/1", in_count, out_count, underflow); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (in_count !== 4'd0 || out_count !== 4'd0) $display("FAIL ar_counts got=%0d/%0d exp=0/0", in_count, out_count); else passed++;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || arch_input_value !== 8'h00) $display("FAIL ar_outputs got=%b/%b/%h exp=0/1/00", out_valid, in_ready, arch_input_value); else passed++;
    total++; if (underflow !== 1'b0) $display("FAIL ar_flags got=%b exp=0", underflow); else passed++;
    #1;
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h77;
    arch_output_enable = 1'b1;
    arch_output_value = 8'h88;
    cycle();
    idle_inputs();
    total++; if (in_count !== 4'd1 || arch_input_value !== 8'h77) $display("FAIL ar_fresh_in got=%0d/%h exp=1/77", in_count, arch_input_value); else passed++;
    total++; if (out_count !== 4'd1 || out_data !== 8'h88) $display("FAIL ar_fresh_out got=%0d/%h exp=1/88", out_count, out_data); else passed++;
    arch_input_enable = 1'b1;
    out_ready = 1'b1;
    cycle();
    idle_inputs();
    $display("async_reset: queues discarded, fresh traffic ok");
  endtask

  task automatic test_random();
    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    logic       uf_m = 1'b0;
    logic       of_m = 1'b0;
    int         fails_before;
    fails_before = total - passed;
    for (int c = 0; c < 400; c++) begin
      logic i_pop, i_push, o_pop, o_push;
      in_valid           = ($urandom_range(0, 1) == 1);
      in_data            = 8'($urandom);
      arch_input_enable  = ($urandom_range(0, 2) == 0);
      arch_output_enable = ($urandom_range(0, 1) == 1);
      arch_output_value  = 8'($urandom);
      out_ready          = ($urandom_range(0, 2) == 0);
      clear_flags        = ($urandom_range(0, 7) == 0);
      #1;
      total++; if (arch_input_value !== ((in_q.size() == 0) ? 8'h00 : in_q[0])) $display("FAIL rnd_aiv c=%0d got=%h", c, arch_input_value); else passed++;
      total++; if (in_ready !== (in_q.size() < DEPTH)) $display("FAIL rnd_in_ready c=%0d got=%b", c, in_ready); else passed++;
      total++; if (out_valid !== (out_q.size() != 0) || (out_q.size() != 0 && out_data !== out_q[0])) $display("FAIL rnd_out c=%0d got=%b/%h", c, out_valid, out_data); else passed++;
      i_pop  = arch_input_enable && (in_q.size() > 0);
      i_push = in_valid && (in_q.size() < DEPTH);
      o_pop  = out_ready && (out_q.size() > 0);
      o_push = arch_output_enable && ((out_q.size() < DEPTH) || o_pop);
      if (clear_flags) begin uf_m = 1'b0; of_m = 1'b0; end
      if (arch_input_enable && in_q.size() == 0) uf_m = 1'b1;
      if (arch_output_enable && !o_push) of_m = 1'b1;
      if (i_pop)  void'(in_q.pop_front());
      if (i_push) in_q.push_back(in_data);
      if (o_pop)  void'(out_q.pop_front());
      if (o_push) out_q.push_back(arch_output_value);
      cycle();
      total++; if (in_count !== 4'(in_q.size()) || out_count !== 4'(out_q.size())) $display("FAIL rnd_counts c=%0d got=%0d/%0d exp=%0d/%0d", c, in_count, out_count, in_q.size(), out_q.size()); else passed++;
      total++; if (underflow !== uf_m || overflow !== of_m) $display("FAIL rnd_flags c=%0d got=%b%b exp=%b%b", c, underflow, overflow, uf_m, of_m); else passed++;
    end
    idle_inputs();
    $display("random: 400 cycles, %0d new failures", (total - passed) - fails_before);
  endtask

  initial begin
    test_reset();
    test_input_basic();
    test_underflow();
    test_input_full_wrap();
    test_output_overflow();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
